// File: rtl/adc_word_align.sv
// adc_word_align: recovers 16-bit ADC samples from the 8-lane DDR capture word.
// A training search selects the half-cycle slip, then aligned samples stream out
// through a small first-word-fall-through FIFO with a valid/ready handshake.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   raw_data[15:0]    : capture word, bit 2i = lane i rising, bit 2i+1 = lane i falling
//   train_en          : ADC is sending TRAIN_PATTERN; start/continue the alignment search
//   m_data, m_valid   : aligned sample stream out (valid = FIFO not empty)
//   m_ready           : downstream accept; pops the FIFO when m_valid is high
//   locked            : alignment found
//   slip              : current half-cycle slip selection
//   align_err         : sticky, MAX_SLIPS slip toggles happened without lock
//   overflow          : sticky, a sample was dropped because the FIFO was full
module adc_word_align #(
  parameter logic [15:0] TRAIN_PATTERN = 16'hA55A,
  parameter int          LOCK_COUNT    = 16,
  parameter int          MAX_SLIPS     = 8,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] raw_data,
  input  logic        train_en,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        locked,
  output logic        slip,
  output logic        align_err,
  output logic        overflow
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int SW = $clog2(MAX_SLIPS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_COUNT - 1);
  localparam logic [SW-1:0] SLIP_LAST = SW'(MAX_SLIPS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   prev_raw;
  logic [15:0]   sample, sample_nxt;
  logic          train_q;
  logic [CW-1:0] match_cnt, match_cnt_nxt;
  logic [SW-1:0] slip_cnt, slip_cnt_nxt;
  logic [1:0]    flush, flush_nxt;
  logic          slip_nxt;
  logic          align_err_nxt;
  logic          push;

  // Sample assembly. With slip=1 the falling bit of the previous word pairs
  // with the rising bit of the current word.
  always_comb begin
    sample_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      if (slip) begin
        sample_nxt[i]     = prev_raw[2*i+1];
        sample_nxt[i+8]   = raw_data[2*i];
      end else begin
        sample_nxt[i]     = raw_data[2*i];
        sample_nxt[i+8]   = raw_data[2*i+1];
      end
    end
  end

  // State register and the registers that travel with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      prev_raw  <= '0;
      sample    <= '0;
      train_q   <= 1'b0;
      match_cnt <= '0;
      slip_cnt  <= '0;
      flush     <= '0;
      slip      <= 1'b0;
      align_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev_raw  <= raw_data;
      sample    <= sample_nxt;
      train_q   <= train_en;
      match_cnt <= match_cnt_nxt;
      slip_cnt  <= slip_cnt_nxt;
      flush     <= flush_nxt;
      slip      <= slip_nxt;
      align_err <= align_err_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt     = state;
    match_cnt_nxt = match_cnt;
    slip_cnt_nxt  = slip_cnt;
    flush_nxt     = flush;
    slip_nxt      = slip;
    align_err_nxt = align_err;
    case (state)
      S_IDLE: begin
        if (train_en) begin
          state_nxt     = S_SEARCH;
          match_cnt_nxt = '0;
          flush_nxt     = '0;
        end
      end
      S_SEARCH: begin
        if (!train_en) begin
          state_nxt = S_IDLE;
        end else if (flush != 2'd0) begin
          // Samples still in flight were assembled with the old slip.
          flush_nxt = flush - 2'd1;
        end else if (sample == TRAIN_PATTERN) begin
          if (match_cnt == LOCK_LAST) begin
            state_nxt     = S_LOCKED;
            match_cnt_nxt = '0;
            slip_cnt_nxt  = '0;
          end else begin
            match_cnt_nxt = match_cnt + CW'(1);
          end
        end else begin
          match_cnt_nxt = '0;
          slip_nxt      = ~slip;
          flush_nxt     = 2'd2;
          if (slip_cnt == SLIP_LAST) begin
            align_err_nxt = 1'b1;
            slip_cnt_nxt  = '0;
          end else begin
            slip_cnt_nxt  = slip_cnt + SW'(1);
          end
        end
      end
      S_LOCKED: begin
        // Only a fresh rising edge of train_en restarts the search; the
        // level left high from the lock itself does not.
        if (train_en && !train_q) begin
          state_nxt     = S_SEARCH;
          match_cnt_nxt = '0;
          flush_nxt     = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic. train_q lines up with the registered sample, so a sample
  // is written exactly when its raw word arrived with train_en low.
  always_comb begin
    locked = (state == S_LOCKED);
    push   = (state == S_LOCKED) && !train_q;
  end

  // Output FIFO, first-word-fall-through.
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr;

  assign full    = (count == FULL_CNT);
  assign m_valid = (count != '0);
  assign pop     = m_valid && m_ready;
  assign wr      = push && (!full || pop);
  assign m_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= sample;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_word_align.sv
// Directed bench for adc_word_align: aligned and skewed training, ramp latency,
// backpressure/overflow, retrain drain, garbage training and reset.
module tb_adc_word_align;

  localparam logic [15:0] PAT = 16'hA55A;

  logic        clk;
  logic        rst;
  logic [15:0] raw_data;
  logic        train_en;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        locked;
  logic        slip;
  logic        align_err;
  logic        overflow;

  int n_chk;
  int n_err;

  adc_word_align dut (
    .clk       (clk),
    .rst       (rst),
    .raw_data  (raw_data),
    .train_en  (train_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .locked    (locked),
    .slip      (slip),
    .align_err (align_err),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Aligned layout: rising bit carries the low byte, falling bit the high byte.
  function automatic logic [15:0] enc_al(input logic [15:0] s);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i]   = s[i];
      r[2*i+1] = s[i+8];
    end
    return r;
  endfunction

  // Half-cycle skew: rising bit carries this sample's high byte, falling bit
  // carries the next sample's low byte.
  function automatic logic [15:0] enc_sk(input logic [15:0] cur, input logic [15:0] nxt);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i]   = cur[i+8];
      r[2*i+1] = nxt[i];
    end
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    logic [15:0] drain [4];
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    m_ready = 1'b1;

    // ---- Aligned training ----
    train_en = 1'b1;
    raw_data = enc_al(PAT);
    do_reset();
    chk("rst_valid", m_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_slip", slip, 0);
    chk("rst_err", align_err, 0);
    chk("rst_ovf", overflow, 0);
    seen = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (slip) seen = 1'b1;
      if (k == 16) chk("al_prelock", locked, 0);
    end
    chk("al_lock", locked, 1);
    chk("al_noslip", seen, 0);

    // ---- Skewed training, then ramp latency/order ----
    train_en = 1'b1;
    raw_data = enc_sk(PAT, PAT);
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 2) chk("sk_slip_toggle", slip, 1);
      if (k == 19) chk("sk_prelock", locked, 0);
    end
    chk("sk_lock", locked, 1);
    chk("sk_slip", slip, 1);
    raw_data = enc_sk(PAT, 16'h0000);
    step();
    train_en = 1'b0;
    for (int j = 0; j < 10; j++) begin
      raw_data = enc_sk(16'(j), 16'(j + 1));
      step();
      if (j == 0) begin
        chk("ramp_lat_empty", m_valid, 0);
      end else begin
        chk("ramp_valid", m_valid, 1);
        chk("ramp_data", m_data, 32'(j - 1));
      end
    end

    // ---- Backpressure, overflow, retrain drain ----
    train_en = 1'b1;
    raw_data = enc_al(PAT);
    m_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 17; k++) step();
    chk("bp_lock", locked, 1);
    train_en = 1'b0;
    m_ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      raw_data = enc_al(16'(j));
      step();
      if (j == 0) chk("bp_empty", m_valid, 0);
      else chk("bp_hold", m_data, 0);
      if (j == 4) chk("bp_full_noovf", overflow, 0);
      if (j == 5) chk("bp_ovf", overflow, 1);
    end
    train_en = 1'b1;
    m_ready = 1'b1;
    raw_data = enc_al(16'd10);
    drain[0] = 16'd1;
    drain[1] = 16'd2;
    drain[2] = 16'd3;
    drain[3] = 16'd9;
    for (int j = 0; j < 4; j++) begin
      step();
      if (j == 0) chk("rt_unlock", locked, 0);
      chk("rt_drain_valid", m_valid, 1);
      chk("rt_drain_data", m_data, drain[j]);
    end
    step();
    chk("rt_drained", m_valid, 0);
    chk("rt_ovf_sticky", overflow, 1);

    // ---- Garbage training, recovery, reset with data queued ----
    train_en = 1'b1;
    m_ready = 1'b1;
    raw_data = 16'h0000;
    do_reset();
    seen = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      raw_data = (k % 2 == 1) ? 16'hFFFF : 16'h0000;
      step();
      if (locked) seen = 1'b1;
      if (k == 2) chk("gb_toggle1", slip, 1);
      if (k == 4) chk("gb_flush_hold", slip, 1);
      if (k == 5) chk("gb_toggle2", slip, 0);
      if (k == 22) chk("gb_err_pre", align_err, 0);
    end
    chk("gb_err", align_err, 1);
    chk("gb_slip_even", slip, 0);
    chk("gb_nolock", seen, 0);
    raw_data = enc_sk(PAT, PAT);
    for (int k = 0; k < 40 && !locked; k++) step();
    chk("gb_relock", locked, 1);
    chk("gb_relock_slip", slip, 1);
    chk("gb_err_sticky", align_err, 1);
    train_en = 1'b0;
    m_ready = 1'b0;
    raw_data = enc_sk(16'h1234, 16'h1234);
    step();
    step();
    step();
    chk("hf_valid", m_valid, 1);
    chk("hf_first", m_data, 16'h125A);
    rst = 1'b1;
    step();
    chk("rst2_valid", m_valid, 0);
    chk("rst2_locked", locked, 0);
    chk("rst2_slip", slip, 0);
    chk("rst2_err", align_err, 0);
    chk("rst2_ovf", overflow, 0);
    rst = 1'b0;
    step();
    chk("rst2_fifo_empty", m_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/adc_word_align.md
Name: adc_word_align

Overview:
- Consumes the raw 16-bit word produced every clk by the ADC DDR capture stage: 8 lanes, with IDDR outputs Q1/Q2 interleaved.
- Determines the half-cycle slip with a training pattern and reorders the bits into ADC samples.
- Delivers samples through a valid/ready stream with a small FIFO.
- Sits between the DDR capture stage and the DSP/packetiser.

Parameters:
- TRAIN_PATTERN, 16'hA55A, expected sample value during training.
- LOCK_COUNT, 16, consecutive matching samples required to declare lock (>=2).
- MAX_SLIPS, 8, slip toggles allowed before flagging align_err.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, same clock as DDR capture stage.
- rst  in  1  synchronous, active-high reset.
- raw_data  in  16  capture word; raw_data[2i] = lane i first (rising) bit, raw_data[2i+1] = lane i second (falling) bit.
- train_en  in  1  level; 1 = ADC is sending TRAIN_PATTERN, run/continue search.
- m_data  out  16  aligned sample.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accept.
- locked  out  1  alignment found.
- slip  out  1  current slip selection (0/1).
- align_err  out  1  sticky; MAX_SLIPS exceeded without lock.
- overflow  out  1  sticky; sample dropped because FIFO full.

Behaviour:
Reset (rst=1 at posedge clk):
- All outputs 0; FSM to IDLE; FIFO emptied; prev-word register 0.
- Reset applies immediately, mid-training or mid-transfer; in-flight FIFO data is discarded.
- align_err and overflow are cleared only by rst.

Sample assembly (registered, 1 cycle):
- slip=0: sample[i] = raw_data[2i], sample[i+8] = raw_data[2i+1] (same cycle).
- slip=1: sample[i] = prev raw_data[2i+1] (previous cycle), sample[i+8] = raw_data[2i] (current cycle).
- prev register updates every cycle regardless of state.

FSM states:
- IDLE:
  - train_en=1 -> SEARCH, match counter=0.
- SEARCH:
  - Each cycle, compare the registered sample to TRAIN_PATTERN.
  - Match: counter+1; when counter reaches LOCK_COUNT -> LOCKED, locked=1.
  - Mismatch: counter=0, toggle slip, slip_count+1. The next 2 cycles are ignored (pipeline flush) before comparing resumes.
  - When slip_count reaches MAX_SLIPS: align_err=1, slip_count=0, continue searching.
  - train_en falling to 0 before lock -> IDLE, slip retained.
- LOCKED:
  - locked=1. While train_en=1, samples are not written to the FIFO.
  - train_en=0: every registered sample is written to the FIFO each cycle (continuous ADC stream, no input backpressure).
  - train_en 0->1 -> SEARCH, locked=0 next cycle, counter=0, slip retained as the starting guess.

FIFO:
- Write when LOCKED and train_en=0, aligned with the registered sample.
- If full and not popping in the same cycle: sample dropped, overflow=1.
- Simultaneous push and pop while full is allowed; no drop.
- Pop on m_valid & m_ready. m_valid = not empty (registered/first-word-fall-through).
- m_data is stable while m_valid=1 & m_ready=0.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.

Latency:
- raw_data at cycle N -> sample register N+1 -> FIFO write at N+1 edge -> m_valid=1 in cycle N+2 (empty FIFO, m_ready=1). Throughput is 1 sample/clk.

Test Plan:
- Reset: assert rst with FIFO half full in LOCKED -> next cycle m_valid=0, locked=0, slip=0, overflow=0, align_err=0.
- Aligned training: drive raw encoding 16'hA55A with slip=0 layout, train_en=1 -> locked=1 exactly LOCK_COUNT+1 cycles after first match, slip=0, no slip toggles.
- Half-cycle skewed training: rising/falling bits offset by one DDR phase -> one mismatch, slip=1, lock after flush + LOCK_COUNT; then train_en=0 with ramp 0x0000,0x0001,... -> m_data ramp in order, first at N+2.
- Backpressure: locked, m_ready=0 for 10 cycles with FIFO_DEPTH=4 -> 4 samples held, overflow=1 on 5th; m_ready=1 -> first 4 ramp values emerge unchanged.
- Garbage training: random raw_data, train_en=1 -> slip toggles every ≥3 cycles, align_err=1 after 8 toggles, locked stays 0; a clean pattern afterwards -> locked=1 with align_err still 1.
- Retrain: LOCKED, train_en 0->1 mid-stream -> FIFO writes stop, locked=0 next cycle; queued samples still drain on m_ready.
